// File: rtl/run_det_sched.sv
// Round-robin scheduler over four serial channels: grants one channel for a
// window of samples and reports the longest run of ones and a threshold hit.
module run_det_sched #(
  parameter int WIN_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       req,
  input  logic [3:0]       din,
  input  logic [WIN_W-1:0] thresh,
  input  logic [WIN_W-1:0] win_len,
  output logic [3:0]       gnt,
  output logic             busy,
  output logic             done,
  output logic             abort,
  output logic [1:0]       done_id,
  output logic             hit,
  output logic [WIN_W-1:0] max_run
);

  typedef enum logic [1:0] {IDLE, RUN, REPORT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [1:0]       chan_q, chan_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [WIN_W-1:0] thr_q, thr_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic [WIN_W-1:0] run_q, run_d;
  logic [WIN_W-1:0] max_q, max_d;
  logic [WIN_W-1:0] cnt_q, cnt_d;
  logic             sticky_q, sticky_d;
  logic             done_q, done_d;
  logic             abort_q, abort_d;
  logic [1:0]       done_id_q, done_id_d;
  logic             hit_q, hit_d;
  logic [WIN_W-1:0] max_run_q, max_run_d;

  // Returns {found, index} of the first set request at or after p, wrapping.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] p);
    logic [1:0] idx;
    pick = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (r[idx]) pick = {1'b1, idx};
    end
  endfunction

  logic [2:0]       sel;
  logic [WIN_W-1:0] thr_eff, win_eff;
  logic [WIN_W-1:0] run_new, max_new, cnt_new;
  logic             sticky_new;

  // A zero threshold or window behaves as one.
  assign thr_eff = (thr_q == '0) ? WIN_W'(1) : thr_q;
  assign win_eff = (win_q == '0) ? WIN_W'(1) : win_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    state_d    = state_q;
    ptr_d      = ptr_q;
    chan_d     = chan_q;
    gnt_d      = gnt_q;
    thr_d      = thr_q;
    win_d      = win_q;
    run_d      = run_q;
    max_d      = max_q;
    cnt_d      = cnt_q;
    sticky_d   = sticky_q;
    done_d     = 1'b0;
    abort_d    = 1'b0;
    done_id_d  = done_id_q;
    hit_d      = hit_q;
    max_run_d  = max_run_q;

    sel        = pick(req, ptr_q);
    run_new    = din[chan_q] ? run_q + WIN_W'(1) : '0;
    max_new    = (run_new > max_q) ? run_new : max_q;
    sticky_new = sticky_q | (run_new >= thr_eff);
    cnt_new    = cnt_q + WIN_W'(1);

    unique case (state_q)
      IDLE: begin
        if (sel[2]) begin
          chan_d   = sel[1:0];
          gnt_d    = 4'b0001 << sel[1:0];
          thr_d    = thresh;
          win_d    = win_len;
          run_d    = '0;
          max_d    = '0;
          cnt_d    = '0;
          sticky_d = 1'b0;
          state_d  = RUN;
        end
      end
      RUN: begin
        if (req[chan_q]) begin
          run_d    = run_new;
          max_d    = max_new;
          cnt_d    = cnt_new;
          sticky_d = sticky_new;
          if (cnt_new == win_eff) begin
            state_d   = REPORT;
            gnt_d     = '0;
            done_d    = 1'b1;
            done_id_d = chan_q;
            hit_d     = sticky_new;
            max_run_d = max_new;
            ptr_d     = chan_q + 2'd1;
          end
        end else begin
          // Requester withdrew: drop the window without touching the results.
          state_d = IDLE;
          gnt_d   = '0;
          abort_d = 1'b1;
          ptr_d   = chan_q + 2'd1;
        end
      end
      REPORT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      chan_q    <= '0;
      gnt_q     <= '0;
      thr_q     <= '0;
      win_q     <= '0;
      run_q     <= '0;
      max_q     <= '0;
      cnt_q     <= '0;
      sticky_q  <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
      done_id_q <= '0;
      hit_q     <= 1'b0;
      max_run_q <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      chan_q    <= chan_d;
      gnt_q     <= gnt_d;
      thr_q     <= thr_d;
      win_q     <= win_d;
      run_q     <= run_d;
      max_q     <= max_d;
      cnt_q     <= cnt_d;
      sticky_q  <= sticky_d;
      done_q    <= done_d;
      abort_q   <= abort_d;
      done_id_q <= done_id_d;
      hit_q     <= hit_d;
      max_run_q <= max_run_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = |gnt_q;
  assign done    = done_q;
  assign abort   = abort_q;
  assign done_id = done_id_q;
  assign hit     = hit_q;
  assign max_run = max_run_q;

endmodule

// File: tb/tb_run_det_sched.sv
// Directed bench for run_det_sched: hit/miss windows, round-robin order,
// abort, asynchronous reset mid-window and degenerate configuration.
module tb_run_det_sched;

  localparam int WIN_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic [3:0]       req;
  logic [3:0]       din;
  logic [WIN_W-1:0] thresh;
  logic [WIN_W-1:0] win_len;
  logic [3:0]       gnt;
  logic             busy;
  logic             done;
  logic             abort;
  logic [1:0]       done_id;
  logic             hit;
  logic [WIN_W-1:0] max_run;

  int total = 0;
  int bad   = 0;

  run_det_sched #(.WIN_W(WIN_W)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .din     (din),
    .thresh  (thresh),
    .win_len (win_len),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .abort   (abort),
    .done_id (done_id),
    .hit     (hit),
    .max_run (max_run)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " gnt"},     32'(gnt),     32'h0);
    check({tag, " busy"},    32'(busy),    32'h0);
    check({tag, " done"},    32'(done),    32'h0);
    check({tag, " abort"},   32'(abort),   32'h0);
    check({tag, " done_id"}, 32'(done_id), 32'h0);
    check({tag, " hit"},     32'(hit),     32'h0);
    check({tag, " max_run"}, 32'(max_run), 32'h0);
  endtask

  task automatic check_result(input string tag, input logic [1:0] id,
                              input logic h, input logic [WIN_W-1:0] mr);
    check({tag, " done"},    32'(done),    32'h1);
    check({tag, " abort"},   32'(abort),   32'h0);
    check({tag, " gnt"},     32'(gnt),     32'h0);
    check({tag, " busy"},    32'(busy),    32'h0);
    check({tag, " done_id"}, 32'(done_id), 32'(id));
    check({tag, " hit"},     32'(hit),     32'(h));
    check({tag, " max_run"}, 32'(max_run), 32'(mr));
  endtask

  initial begin
    logic [4:0] pat;

    reset = 1'b0; req = '0; din = '0; thresh = '0; win_len = '0;
    #12;
    check_idle_outputs("por");
    reset = 1'b1;
    step();

    // Single-channel hit; thresh/win_len changed after grant must be ignored.
    req = 4'b0100; thresh = 4'd3; win_len = 4'd5;
    step();
    check("hit grant", 32'(gnt), 32'h4);
    check("hit busy",  32'(busy), 32'h1);
    thresh = 4'd15; win_len = 4'd1;
    pat = 5'b10111;  // din[2] = 1,1,1,0,1 in order (LSB first)
    for (int k = 0; k < 5; k++) begin
      check($sformatf("hit gnt cyc%0d", k + 1), 32'(gnt), 32'h4);
      check($sformatf("hit done low cyc%0d", k + 1), 32'(done), 32'h0);
      din = pat[k] ? 4'b0100 : 4'b1011;
      step();
    end
    check_result("hit report", 2'd2, 1'b1, 4'd3);
    req = '0;
    step();
    check("hit done one cycle", 32'(done), 32'h0);
    check("hit hold", 32'(hit), 32'h1);
    check("hit hold max", 32'(max_run), 32'h3);

    // Single-channel miss: din[2] = 1,1,0,1,1.
    req = 4'b0100; thresh = 4'd3; win_len = 4'd5;
    step();
    pat = 5'b11011;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("miss gnt cyc%0d", k + 1), 32'(gnt), 32'h4);
      din = pat[k] ? 4'b0100 : 4'b0000;
      step();
    end
    check_result("miss report", 2'd2, 1'b0, 4'd2);
    req = '0;
    step();

    // ptr is now 3: with ch0 and ch3 requesting, ch3 wins.
    req = 4'b1001; win_len = 4'd1; din = '0;
    step();
    check("ptr3 grant", 32'(gnt), 32'h8);
    step();
    check_result("ptr3 report", 2'd3, 1'b0, 4'd0);
    req = '0;
    step();

    // Round-robin from reset with all channels requesting.
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_idle_outputs("rr reset");
    req = 4'b1111; thresh = 4'd1; win_len = 4'd1; din = 4'hF;
    reset = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rr gnt %0d", i), 32'(gnt), 32'(4'b0001 << (i % 4)));
      step();
      check_result($sformatf("rr report %0d", i), 2'(i % 4), 1'b1, 4'd1);
      if (i == 4) req = '0;
      step();
      check($sformatf("rr gap gnt %0d", i), 32'(gnt), 32'h0);
      check($sformatf("rr gap done %0d", i), 32'(done), 32'h0);
      if (i < 4) step();
    end

    // Abort: ch1 drops its request in its third grant cycle.
    req = 4'b0110; thresh = 4'd1; win_len = 4'd6; din = '0;
    step();
    check("abort gnt c1", 32'(gnt), 32'h2);
    step();
    check("abort gnt c2", 32'(gnt), 32'h2);
    step();
    check("abort gnt c3", 32'(gnt), 32'h2);
    req = 4'b0100;
    step();
    check("abort pulse", 32'(abort), 32'h1);
    check("abort no done", 32'(done), 32'h0);
    check("abort gnt", 32'(gnt), 32'h0);
    check("abort busy", 32'(busy), 32'h0);
    check("abort keep id", 32'(done_id), 32'h0);
    check("abort keep hit", 32'(hit), 32'h1);
    check("abort keep max", 32'(max_run), 32'h1);
    step();
    check("abort next gnt", 32'(gnt), 32'h4);
    check("abort one cycle", 32'(abort), 32'h0);
    req = '0;
    step();
    check("abort2 pulse", 32'(abort), 32'h1);
    step();

    // Reset during the second RUN cycle of ch3 (ptr is 3 here).
    req = 4'b1001; win_len = 4'd6;
    step();
    check("rst gnt c1", 32'(gnt), 32'h8);
    step();
    check("rst gnt c2", 32'(gnt), 32'h8);
    reset = 1'b0;
    #1;
    check_idle_outputs("rst async");
    reset = 1'b1;
    step();
    check("rst regrant ch0", 32'(gnt), 32'h1);
    check("rst no abort", 32'(abort), 32'h0);
    check("rst no done", 32'(done), 32'h0);
    req = '0;
    step();
    check("rst abort", 32'(abort), 32'h1);
    step();

    // Degenerate config: thresh=0, win_len=0 behave as one.
    req = 4'b0001; thresh = '0; win_len = '0; din = 4'hF;
    step();
    check("deg1 gnt", 32'(gnt), 32'h1);
    step();
    check_result("deg1 report", 2'd0, 1'b1, 4'd1);
    req = '0;
    step();
    check("deg1 single gnt", 32'(gnt), 32'h0);
    req = 4'b0001; din = '0;
    step();
    check("deg0 gnt", 32'(gnt), 32'h1);
    step();
    check_result("deg0 report", 2'd0, 1'b0, 4'd0);
    req = '0;
    step();
    check("deg0 single gnt", 32'(gnt), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/run_det_sched.md
RUN_DET_SCHED -- requirements
Module: run_det_sched

Interface
REQ-001 Parameter: WIN_W, default 4, width of win_len, run counters and max_run; supported values 2..6.
REQ-002 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: req  input  4  per-channel request, level; held high by the requester until done or abort for that channel.
REQ-005 Port: din  input  4  per-channel serial data bit; only the granted channel is sampled.
REQ-006 Port: thresh  input  WIN_W  run-length threshold of consecutive ones; latched at grant.
REQ-007 Port: win_len  input  WIN_W  number of samples per grant; latched at grant.
REQ-008 Port: gnt  output  4  one-hot grant, registered; all zero when no channel is granted.
REQ-009 Port: busy  output  1  high while a channel is granted (state RUN).
REQ-010 Port: done  output  1  one-cycle pulse marking window completion.
REQ-011 Port: abort  output  1  one-cycle pulse marking a window terminated early.
REQ-012 Port: done_id  output  2  channel index of the last completed window.
REQ-013 Port: hit  output  1  high if the last completed window contained a run of ones >= effective threshold.
REQ-014 Port: max_run  output  WIN_W  longest run of consecutive ones in the last completed window.

Function
REQ-015 The FSM SHALL have three states: IDLE, RUN and REPORT.
REQ-016 In IDLE with any req bit high at an edge, the block SHALL select the first set req bit scanning from ptr upward modulo 4, then: assert the matching gnt bit; latch thresh and win_len; clear the run counter, max counter, sample counter and sticky hit; enter RUN.
REQ-017 ptr SHALL be a 2-bit round-robin pointer. On done or abort of channel c it SHALL load (c+1) mod 4.
REQ-018 The effective threshold SHALL be max(thresh,1) and the effective window max(win_len,1).
REQ-019 In RUN, each edge with req[c] high SHALL sample din[c], giving exactly one sample per gnt-high cycle:
- din=1: run counter increments;
- din=0: run counter clears;
- max counter tracks the maximum of the new run value;
- sticky hit sets when the new run value >= effective threshold.
REQ-020 When the sample counter reaches the effective window at an edge, the block SHALL:
- enter REPORT;
- clear gnt and busy;
- pulse done high for that one cycle;
- update done_id, hit and max_run to include that final sample.
REQ-021 REPORT SHALL last exactly one cycle and SHALL return to IDLE. A new grant is therefore visible no earlier than 2 cycles after done rises.
REQ-022 In RUN, if req[c] is low at an edge, the block SHALL:
- take no sample;
- clear gnt and busy;
- pulse abort for one cycle;
- leave done_id, hit and max_run unchanged;
- advance ptr;
- return to IDLE.
REQ-023 done and abort SHALL never be high in the same cycle.
REQ-024 Changes on din or req of non-granted channels during RUN SHALL have no effect.
REQ-025 Changes on thresh and win_len after grant SHALL have no effect until the next grant.
REQ-026 gnt SHALL be one-hot or zero at all times.
REQ-027 busy SHALL equal the OR of gnt.
REQ-028 done_id, hit and max_run SHALL hold their values between done pulses.

Reset
REQ-029 While reset is low, the block SHALL asynchronously force:
- state IDLE, ptr 0;
- gnt 0, busy 0, done 0, abort 0;
- done_id 0, hit 0, max_run 0;
- all internal counters 0.
REQ-030 Reset asserted mid-RUN SHALL discard the window with no done and no abort pulse.
REQ-031 After reset deassertion, arbitration SHALL begin at the first rising edge.

Verification
REQ-032 The bench SHALL cover these directed scenarios:
- Single-channel hit: req=0100, thresh=3, win_len=5, din[2]=1,1,1,0,1 -> gnt=0100 for 5 cycles; done pulse; done_id=2, hit=1, max_run=3.
- Single-channel miss: same setup, din[2]=1,1,0,1,1 -> hit=0, max_run=2; ptr=3 afterwards.
- Round-robin: req=1111 held after reset, win_len=1 -> grant order ch0,1,2,3,0; each done followed by 2 cycles before the next gnt.
- Abort: req=0010 with win_len=6, req[1] dropped at the 3rd gnt cycle -> abort pulse; gnt=0; no done; prior results unchanged; if req[2] is high, next gnt=0100.
- Reset mid-operation: reset low during RUN cycle 2 -> all outputs 0 immediately; after release, req=1001 grants ch0 first.
- Degenerate configuration: thresh=0, win_len=0, din=1 -> exactly one gnt cycle; hit=1, max_run=1. Repeat with din=0 -> hit=0, max_run=0.
